// File: rtl/pp_pkg.sv
// pp_pkg: shared types and helpers for the path-parser
// dispatcher and its in-order tag FIFO.
`ifndef CHUNK_LEN_NBITS
`define CHUNK_LEN_NBITS 16
`endif

package pp_pkg;

  localparam int CHUNK_LEN_W = `CHUNK_LEN_NBITS;
  localparam int PP_NUM      = 4;
  localparam int PP_ID_W     = 2;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ALLOC = 2'd1,
    XFER  = 2'd2
  } pp_state_e;

  typedef struct packed {
    logic [PP_ID_W-1:0] pp_id;
    logic               ptr;
  } pp_tag_t;

  function automatic int slot_nbits(input int num_pp);
    return $clog2(2 * num_pp);
  endfunction

endpackage

// File: rtl/pp_dispatch_if.sv
// pp_dispatch_if: ingress beats, parser steering, tag
// FIFO head and status of the path-parser dispatcher.
interface pp_dispatch_if
  import pp_pkg::*;
#(
  parameter int NUM_PP      = PP_NUM,
  parameter int PP_ID_NBITS = PP_ID_W,
  parameter int LEN_NBITS   = CHUNK_LEN_W
);

  logic                   in_valid;
  logic                   in_sop;
  logic                   in_eop;
  logic [LEN_NBITS-1:0]   in_len;
  logic                   in_ready;
  logic [2*NUM_PP-1:0]    path_parser_ready;
  logic                   pp_valid;
  logic                   pp_eop;
  logic [LEN_NBITS-1:0]   pp_len;
  logic [PP_ID_NBITS-1:0] pp_id;
  logic                   rd_ptr;
  logic                   tag_valid;
  logic [PP_ID_NBITS:0]   tag;
  logic                   tag_pop;
  logic                   err_short;

  modport master (
    output in_valid, in_sop, in_eop, in_len,
    output path_parser_ready, tag_pop,
    input  in_ready, pp_valid, pp_eop, pp_len,
    input  pp_id, rd_ptr, tag_valid, tag,
    input  err_short
  );

  modport slave (
    input  in_valid, in_sop, in_eop, in_len,
    input  path_parser_ready, tag_pop,
    output in_ready, pp_valid, pp_eop, pp_len,
    output pp_id, rd_ptr, tag_valid, tag,
    output err_short
  );

endinterface

// File: rtl/pp_tag_fifo.sv
// pp_tag_fifo: generic synchronous FIFO; a pop frees its
// entry in the same cycle, so push on full is legal then.
module pp_tag_fifo #(
  parameter int WIDTH = 3,
  parameter int DEPTH = 8
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH) + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_q, wr_d;
  logic [AW-1:0]    rd_q, rd_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             do_push;
  logic             do_pop;

  function automatic logic [AW-1:0] inc(
    input logic [AW-1:0] p
  );
    return (p == AW'(DEPTH - 1)) ? '0 : p + AW'(1);
  endfunction

  assign empty   = (cnt_q == '0);
  assign full    = (cnt_q == CW'(DEPTH));
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);
  assign dout    = mem_q[rd_q];

  // Next pointers and occupancy.
  always_comb begin
    wr_d  = wr_q;
    rd_d  = rd_q;
    cnt_d = cnt_q;
    if (do_push) wr_d = inc(wr_q);
    if (do_pop)  rd_d = inc(rd_q);
    unique case ({do_push, do_pop})
      2'b10:   cnt_d = cnt_q + CW'(1);
      2'b01:   cnt_d = cnt_q - CW'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  // Pointer and count state.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      wr_q  <= wr_d;
      rd_q  <= rd_d;
      cnt_q <= cnt_d;
    end
  end

  // Storage array; contents are don't-care while empty.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_q] <= din;
  end

endmodule

// File: rtl/pp_dispatch.sv
// pp_dispatch: round-robin steering of ingress chunks onto
// ping-pong parser slots, recording slot order in a FIFO.
module pp_dispatch
  import pp_pkg::*;
#(
  parameter int NUM_PP      = PP_NUM,
  parameter int PP_ID_NBITS = PP_ID_W,
  parameter int LEN_NBITS   = CHUNK_LEN_W
) (
  input  logic         clk,
  input  logic         rstn,
  pp_dispatch_if.slave io
);

  localparam int NSLOT = 2 * NUM_PP;
  localparam int SW    = slot_nbits(NUM_PP);
  localparam int TAG_W = PP_ID_NBITS + 1;

  pp_state_e              state_q, state_d;
  logic [SW-1:0]          rr_q, rr_d;
  logic [SW-1:0]          win_q, win_d;
  logic [NSLOT-1:0]       pend_q, pend_d;
  logic [LEN_NBITS-1:0]   len_q, len_d;
  logic                   err_q, err_d;
  logic                   ppv_q, ppv_d;
  logic                   ppe_q, ppe_d;
  logic [PP_ID_NBITS-1:0] id_q, id_d;
  logic                   ptr_q, ptr_d;
  logic [LEN_NBITS-1:0]   plen_q, plen_d;

  logic [NSLOT-1:0]       avail;
  logic [SW-1:0]          pick, idx;
  logic                   found;
  logic                   rdy;
  logic                   push;
  logic                   fwd;
  logic                   fwd_eop;
  logic                   full, empty;
  logic [TAG_W-1:0]       din, dout;

  // A slot granted earlier stays masked until its ready
  // is seen low, so a stale ready cannot re-grant it.
  assign avail = io.path_parser_ready & ~pend_q;

  // First available slot after the last winner.
  always_comb begin
    found = 1'b0;
    pick  = rr_q;
    idx   = rr_q;
    for (int k = 1; k <= NSLOT; k++) begin
      idx = rr_q + SW'(k);
      if (!found && avail[idx]) begin
        found = 1'b1;
        pick  = idx;
      end
    end
  end

  assign din = {win_q[PP_ID_NBITS-1:0],
                win_q[PP_ID_NBITS]};

  pp_tag_fifo #(
    .WIDTH (TAG_W),
    .DEPTH (NSLOT)
  ) u_tag_fifo (
    .clk   (clk),
    .rstn  (rstn),
    .push  (push),
    .din   (din),
    .pop   (io.tag_pop),
    .dout  (dout),
    .full  (full),
    .empty (empty)
  );

  // Chunk sequencing: grant, accept sop, stream to eop.
  always_comb begin
    state_d = state_q;
    rr_d    = rr_q;
    win_d   = win_q;
    len_d   = len_q;
    err_d   = err_q;
    pend_d  = pend_q & io.path_parser_ready;
    rdy     = 1'b0;
    push    = 1'b0;
    fwd     = 1'b0;
    fwd_eop = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (io.in_valid && !io.in_sop) begin
          rdy = 1'b1;
        end else if (io.in_valid && found &&
                     (!full || io.tag_pop)) begin
          state_d = ALLOC;
          win_d   = pick;
          rr_d    = pick;
          len_d   = io.in_len;
        end
      end
      ALLOC: begin
        rdy = 1'b1;
        if (io.in_valid) begin
          if (io.in_eop) begin
            err_d   = 1'b1;
            state_d = IDLE;
          end else begin
            push          = 1'b1;
            pend_d[win_q] = 1'b1;
            fwd           = 1'b1;
            state_d       = XFER;
          end
        end
      end
      XFER: begin
        if (io.in_valid && io.in_sop) begin
          fwd     = 1'b1;
          fwd_eop = 1'b1;
          state_d = IDLE;
        end else begin
          rdy = 1'b1;
          if (io.in_valid) begin
            fwd     = 1'b1;
            fwd_eop = io.in_eop;
            if (io.in_eop) state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Registered parser-side beat; steering fields hold.
  always_comb begin
    ppv_d  = fwd;
    ppe_d  = fwd & fwd_eop;
    id_d   = id_q;
    ptr_d  = ptr_q;
    plen_d = plen_q;
    if (fwd) begin
      id_d   = win_q[PP_ID_NBITS-1:0];
      ptr_d  = win_q[PP_ID_NBITS];
      plen_d = len_q;
    end
  end

  // Control and output state.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= IDLE;
      rr_q    <= '0;
      win_q   <= '0;
      pend_q  <= '0;
      len_q   <= '0;
      err_q   <= 1'b0;
      ppv_q   <= 1'b0;
      ppe_q   <= 1'b0;
      id_q    <= '0;
      ptr_q   <= 1'b0;
      plen_q  <= '0;
    end else begin
      state_q <= state_d;
      rr_q    <= rr_d;
      win_q   <= win_d;
      pend_q  <= pend_d;
      len_q   <= len_d;
      err_q   <= err_d;
      ppv_q   <= ppv_d;
      ppe_q   <= ppe_d;
      id_q    <= id_d;
      ptr_q   <= ptr_d;
      plen_q  <= plen_d;
    end
  end

  assign io.in_ready  = rstn & rdy;
  assign io.pp_valid  = ppv_q;
  assign io.pp_eop    = ppe_q;
  assign io.pp_id     = id_q;
  assign io.rd_ptr    = ptr_q;
  assign io.pp_len    = plen_q;
  assign io.tag_valid = ~empty;
  assign io.tag       = dout;
  assign io.err_short = err_q;

endmodule
